// File: rtl/updown_count_decoder.sv
// Recovers counting direction from an observed up/down counter bus, flags and counts illegal steps.
// Optional macro UPDOWN_DEC_STRICT_HOLD_EN: a repeated value while locked is treated as an illegal step.
module updown_count_decoder #(
  parameter int WIDTH = 4,
  parameter int ERR_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] count,
  output logic             mode,
  output logic             mode_valid,
  output logic             step_err,
  output logic             rev_pulse,
  output logic [ERR_W-1:0] err_count
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ACQ   = 2'd1,
    ST_LOCK  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    STEP_HOLD = 2'd0,
    STEP_UP   = 2'd1,
    STEP_DOWN = 2'd2,
    STEP_BAD  = 2'd3
  } step_e;

  localparam logic [WIDTH-1:0] DELTA_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] DELTA_UP   = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] DELTA_DOWN = {WIDTH{1'b1}};
  localparam logic [ERR_W-1:0] ERR_MAX    = {ERR_W{1'b1}};
  localparam logic [ERR_W-1:0] ERR_ONE    = {{(ERR_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [WIDTH-1:0] prev_q;
  logic             mode_q, mode_d;
  logic             valid_q, valid_d;
  logic             step_err_q, step_err_d;
  logic             rev_q, rev_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [WIDTH-1:0] delta_s;
  step_e            step_s;
  logic             fault_s;

  assign delta_s = count - prev_q;

  always_comb begin
    step_s = STEP_BAD;
    if (delta_s == DELTA_ZERO) begin
      step_s = STEP_HOLD;
    end else if (delta_s == DELTA_UP) begin
      step_s = STEP_UP;
    end else if (delta_s == DELTA_DOWN) begin
      step_s = STEP_DOWN;
    end else begin
      step_s = STEP_BAD;
    end
  end

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    valid_d    = valid_q;
    step_err_d = 1'b0;
    rev_d      = 1'b0;
    fault_s    = 1'b0;
    case (state_q)
      ST_EMPTY: state_d = ST_ACQ;
      ST_ACQ: begin
        case (step_s)
          STEP_UP: begin
            mode_d  = 1'b1;
            valid_d = 1'b1;
            state_d = ST_LOCK;
          end
          STEP_DOWN: begin
            mode_d  = 1'b0;
            valid_d = 1'b1;
            state_d = ST_LOCK;
          end
          STEP_BAD: fault_s = 1'b1;
          default:  fault_s = 1'b0;
        endcase
      end
      ST_LOCK: begin
        // Locking from ACQ never counts as a reversal; only a flip while locked does.
        case (step_s)
          STEP_UP: begin
            mode_d = 1'b1;
            rev_d  = ~mode_q;
          end
          STEP_DOWN: begin
            mode_d = 1'b0;
            rev_d  = mode_q;
          end
`ifdef UPDOWN_DEC_STRICT_HOLD_EN
          STEP_HOLD: fault_s = 1'b1;
`else
          STEP_HOLD: fault_s = 1'b0;
`endif
          default: fault_s = 1'b1;
        endcase
      end
      default: state_d = ST_EMPTY;
    endcase
    if (fault_s) begin
      step_err_d = 1'b1;
      valid_d    = 1'b0;
      state_d    = ST_ACQ;
    end else begin
      step_err_d = 1'b0;
    end
    if (fault_s && (err_q != ERR_MAX)) begin
      err_d = err_q + ERR_ONE;
    end else begin
      err_d = err_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_EMPTY;
      prev_q     <= {WIDTH{1'b0}};
      mode_q     <= 1'b0;
      valid_q    <= 1'b0;
      step_err_q <= 1'b0;
      rev_q      <= 1'b0;
      err_q      <= {ERR_W{1'b0}};
    end else begin
      state_q    <= state_d;
      prev_q     <= count;
      mode_q     <= mode_d;
      valid_q    <= valid_d;
      step_err_q <= step_err_d;
      rev_q      <= rev_d;
      err_q      <= err_d;
    end
  end

  assign mode       = mode_q;
  assign mode_valid = valid_q;
  assign step_err   = step_err_q;
  assign rev_pulse  = rev_q;
  assign err_count  = err_q;

endmodule
